ex_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/ex_stage_if.sv | 44 ++++
 rtl/alu.sv | 37 +++
 rtl/ex_stage.sv | 108 ++++++++++
 tb/tb_ex_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU operation codes shared by the ALU control decoder and the execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, grouped as one bundle.
interface ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [3:0]       alu_ctr;
  logic             jr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] store_data;
  logic [REGW-1:0]  wr_reg;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;

  logic             ex_valid;
  logic [WIDTH-1:0] ex_alu_result;
  logic             ex_zero;
  logic [WIDTH-1:0] ex_store_data;
  logic [REGW-1:0]  ex_wr_reg;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             jr_taken;
  logic [WIDTH-1:0] jr_target;

  modport master (
    output stall, flush, id_valid, alu_ctr, jr, src_a, src_b, shamt,
           store_data, wr_reg, reg_write, mem_read, mem_write,
    input  ex_valid, ex_alu_result, ex_zero, ex_store_data, ex_wr_reg,
           ex_reg_write, ex_mem_read, ex_mem_write, jr_taken, jr_target
  );

  modport slave (
    input  stall, flush, id_valid, alu_ctr, jr, src_a, src_b, shamt,
           store_data, wr_reg, reg_write, mem_read, mem_write,
    output ex_valid, ex_alu_result, ex_zero, ex_store_data, ex_wr_reg,
           ex_reg_write, ex_mem_read, ex_mem_write, jr_taken, jr_target
  );
endinterface

// File: rtl/alu.sv
// Combinational MIPS ALU; arithmetic wraps modulo 2^WIDTH, unused codes give 0.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Operation select
  always_comb begin
    result = {WIDTH{1'b0}};
    case (alu_ctr)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_LUI:  result = b << 5'd16;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      default:  result = {WIDTH{1'b0}};
    endcase
  end

  assign zero = ~|result;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, EX/MEM pipeline register and jr redirect.
module ex_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  logic [WIDTH-1:0] alu_result_s;
  logic             alu_zero_s;
  logic             keep_ctl_s;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] store_data_d, store_data_q;
  logic [REGW-1:0]  wr_reg_d, wr_reg_q;
  logic             reg_write_d, reg_write_q;
  logic             mem_read_d, mem_read_q;
  logic             mem_write_d, mem_write_q;

  alu #(.WIDTH(WIDTH)) u_alu (
    .alu_ctr (bus.alu_ctr),
    .a       (bus.src_a),
    .b       (bus.src_b),
    .shamt   (bus.shamt),
    .result  (alu_result_s),
    .zero    (alu_zero_s)
  );

  // A jr never writes back or touches memory, and an empty slot issues nothing.
  assign keep_ctl_s = bus.id_valid & ~bus.jr;

  // EX/MEM next state: flush beats stall beats load
  always_comb begin
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    zero_d       = zero_q;
    store_data_d = store_data_q;
    wr_reg_d     = wr_reg_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if (bus.flush) begin
      valid_d      = 1'b0;
      alu_result_d = {WIDTH{1'b0}};
      zero_d       = 1'b0;
      store_data_d = {WIDTH{1'b0}};
      wr_reg_d     = {REGW{1'b0}};
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
    end else if (bus.stall) begin
      valid_d      = valid_q;
      alu_result_d = alu_result_q;
    end else begin
      valid_d      = bus.id_valid;
      alu_result_d = alu_result_s;
      zero_d       = alu_zero_s;
      store_data_d = bus.store_data;
      wr_reg_d     = bus.wr_reg;
      reg_write_d  = bus.reg_write & keep_ctl_s;
      mem_read_d   = bus.mem_read  & keep_ctl_s;
      mem_write_d  = bus.mem_write & keep_ctl_s;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_result_q <= {WIDTH{1'b0}};
      zero_q       <= 1'b0;
      store_data_q <= {WIDTH{1'b0}};
      wr_reg_q     <= {REGW{1'b0}};
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      store_data_q <= store_data_d;
      wr_reg_q     <= wr_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_alu_result = alu_result_q;
  assign bus.ex_zero       = zero_q;
  assign bus.ex_store_data = store_data_q;
  assign bus.ex_wr_reg     = wr_reg_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;

  // Redirect is zero-latency so fetch can squash IF/ID on the next edge.
  assign bus.jr_taken  = bus.id_valid & bus.jr & ~bus.stall;
  assign bus.jr_target = bus.src_a;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed edge cases plus randomized traffic
// compared every cycle against a behavioural EX/MEM model.
module tb_ex_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if #(.WIDTH(32), .REGW(5)) bus ();

  ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  // behavioural EX/MEM contents
  logic        m_valid, m_zero, m_rw, m_mr, m_mw;
  logic [31:0] m_res, m_sd;
  logic [4:0]  m_wr;

  function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    logic [31:0] fill;
    fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (c)
      4'd1:    return a + b;
      4'd2:    return a + ~b + 32'd1;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd9:    return ~(a | b);
      4'd6:    return b * 32'd65536;
      4'd7:    return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd8:    return {31'd0, a < b};
      4'd10:   return b << sh;
      4'd11:   return b >> sh;
      4'd12:   return (b >> sh) | fill;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_valid, m_zero, m_rw, m_mr, m_mw} <= 5'd0;
      m_res <= 32'd0; m_sd <= 32'd0; m_wr <= 5'd0;
    end else if (bus.flush) begin
      {m_valid, m_zero, m_rw, m_mr, m_mw} <= 5'd0;
      m_res <= 32'd0; m_sd <= 32'd0; m_wr <= 5'd0;
    end else if (!bus.stall) begin
      m_valid <= bus.id_valid;
      m_res   <= ref_alu(bus.alu_ctr, bus.src_a, bus.src_b, bus.shamt);
      m_zero  <= (ref_alu(bus.alu_ctr, bus.src_a, bus.src_b, bus.shamt) == 32'd0);
      m_sd    <= bus.store_data;
      m_wr    <= bus.wr_reg;
      m_rw    <= bus.reg_write & bus.id_valid & !bus.jr;
      m_mr    <= bus.mem_read  & bus.id_valid & !bus.jr;
      m_mw    <= bus.mem_write & bus.id_valid & !bus.jr;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",  {31'd0, bus.ex_valid},     {31'd0, m_valid});
      chk("result", bus.ex_alu_result,         m_res);
      chk("zero",   {31'd0, bus.ex_zero},      {31'd0, m_zero});
      chk("sdata",  bus.ex_store_data,         m_sd);
      chk("wr_reg", {27'd0, bus.ex_wr_reg},    {27'd0, m_wr});
      chk("rw",     {31'd0, bus.ex_reg_write}, {31'd0, m_rw});
      chk("mr",     {31'd0, bus.ex_mem_read},  {31'd0, m_mr});
      chk("mw",     {31'd0, bus.ex_mem_write}, {31'd0, m_mw});
      chk("jr_taken",  {31'd0, bus.jr_taken},
          {31'd0, bus.id_valid & bus.jr & !bus.stall});
      chk("jr_target", bus.jr_target, bus.src_a);
    end
  end

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bus.alu_ctr = c; bus.src_a = a; bus.src_b = b; bus.shamt = sh;
    bus.id_valid = 1'b1; bus.jr = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.reg_write = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.store_data = a ^ b; bus.wr_reg = sh;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op_check(input string nm, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp_res, input logic exp_zero);
    set_op(c, a, b, sh);
    tick();
    chk({nm, "_res"},  bus.ex_alu_result, exp_res);
    chk({nm, "_zero"}, {31'd0, bus.ex_zero}, {31'd0, exp_zero});
  endtask

  initial begin
    rst = 1'b1;
    set_op(4'd0, 32'd0, 32'd0, 5'd0);
    bus.id_valid = 1'b0; bus.reg_write = 1'b0;
    #1;
    chk("rst_valid",  {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_result", bus.ex_alu_result, 32'd0);
    chk("rst_rw",     {31'd0, bus.ex_reg_write}, 32'd0);
    #6;
    rst = 1'b0;
    chk_en = 1'b1;

    op_check("add",  ALU_ADD,  32'd5, 32'd7, 5'd0, 32'd12, 1'b0);
    chk("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    op_check("sub",  ALU_SUB,  32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
    op_check("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    op_check("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);
    op_check("sra",  ALU_SRA,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    op_check("lui",  ALU_LUI,  32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);
    op_check("beq",  ALU_SUB,  32'd9, 32'd9, 5'd0, 32'd0, 1'b1);
    op_check("unused", 4'b1111, 32'd3, 32'd4, 5'd0, 32'd0, 1'b1);

    // hold for three cycles while inputs change
    op_check("pre_stall", ALU_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_op(ALU_OR, $urandom, $urandom, 5'(i + 1));
      bus.stall = 1'b1;
      tick();
      chk("stall_res", bus.ex_alu_result, 32'd7);
      chk("stall_valid", {31'd0, bus.ex_valid}, 32'd1);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_rw",    {31'd0, bus.ex_reg_write}, 32'd0);

    // jr redirect
    set_op(ALU_ADD, 32'h0040_0020, 32'd0, 5'd0);
    bus.jr = 1'b1; bus.mem_write = 1'b1;
    #1;
    chk("jr_taken_now",  {31'd0, bus.jr_taken}, 32'd1);
    chk("jr_target_now", bus.jr_target, 32'h0040_0020);
    tick();
    chk("jr_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    chk("jr_mw", {31'd0, bus.ex_mem_write}, 32'd0);
    bus.stall = 1'b1;
    #1;
    chk("jr_stalled", {31'd0, bus.jr_taken}, 32'd0);

    // empty slot
    set_op(ALU_ADD, 32'd1, 32'd2, 5'd0);
    bus.id_valid = 1'b0; bus.mem_write = 1'b1;
    tick();
    chk("inv_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("inv_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
    chk("inv_mw",    {31'd0, bus.ex_mem_write}, 32'd0);

    // reset arriving during a stall clears held contents without a clock edge
    op_check("pre_rst", ALU_ADD, 32'd20, 32'd22, 5'd0, 32'd42, 1'b0);
    bus.stall = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("midrst_res",   bus.ex_alu_result, 32'd0);
    tick();
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.alu_ctr    = 4'($urandom);
      bus.src_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.src_b      = ($urandom_range(0, 3) == 0) ? bus.src_a : $urandom;
      bus.shamt      = 5'($urandom);
      bus.store_data = $urandom;
      bus.wr_reg     = 5'($urandom);
      bus.id_valid   = ($urandom_range(0, 3) != 0);
      bus.jr         = ($urandom_range(0, 7) == 0);
      bus.stall      = ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
      bus.reg_write  = 1'($urandom);
      bus.mem_read   = 1'($urandom);
      bus.mem_write  = 1'($urandom);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
